// File: rtl/nibble_unload16b.sv
// nibble_unload16b: replays a captured 16-bit word MSB-first as four nibbles,
// advancing one nibble per rising edge of the unload button.
// Optional feature macro: UNLOAD_BTN_SYNC_EN adds a 2-flop button synchronizer
// (2 extra cycles of press latency). When it is undefined the button is taken
// as already synchronous to clk.
module nibble_unload16b (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        unloadButton_s,
    output logic [3:0]  nib_out,
    output logic        nib_valid,
    output logic [1:0]  nib_idx,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        btn_s;
    logic        btn_prev;
    logic        press;

`ifdef UNLOAD_BTN_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer; reset high so a button held through reset reads as old news
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments keep each flop sampling the pre-edge value,
            // which is what makes this a two-stage shift rather than one wire.
            sync_q <= {sync_q[0], unloadButton_s};
        end
    end

    assign btn_s = sync_q[1];
`else
    assign btn_s = unloadButton_s;
`endif

    // Button history for rising-edge detect; holding the button never re-fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn_s;
        end
    end

    assign press = btn_s & ~btn_prev;

    // State, shift register and nibble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: shreg is an ordinary datapath register (not a RAM), so it is
            // cleared on reset along with the control state.
            state <= IDLE;
            shreg <= 16'h0000;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, shift on press in SHOW, one cycle in DONE
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                // Presses here are dropped; an accept in the same cycle wins.
                if (word_valid) begin
                    shreg_nxt = word_in;
                    cnt_nxt   = 2'd0;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    if (cnt == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        shreg_nxt = {shreg[11:0], 4'h0};
                        cnt_nxt   = cnt + 2'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registers only; no input reaches them combinationally
    assign word_ready = (state == IDLE);
    assign nib_valid  = (state == SHOW);
    assign nib_out    = (state == SHOW) ? shreg[15:12] : 4'h0;
    assign nib_idx    = (state == SHOW) ? cnt : 2'd0;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_nibble_unload16b.sv
// tb_nibble_unload16b: scoreboard bench for nibble_unload16b. Stimulus tasks update a
// word-level model and push expected nibble/done events; a negedge monitor pops them
// whenever the DUT presents a new nibble or a done pulse.
module tb_nibble_unload16b;

`ifdef UNLOAD_BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        btn;
    logic [3:0]  nib_out;
    logic        nib_valid;
    logic [1:0]  nib_idx;
    logic        done;

    nibble_unload16b dut (
        .clk            (clk),
        .rst            (rst),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .unloadButton_s (btn),
        .nib_out        (nib_out),
        .nib_valid      (nib_valid),
        .nib_idx        (nib_idx),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [3:0] nib;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Word-level reference model
    bit          m_active = 0;
    logic [15:0] m_word   = 16'h0;
    int          m_cnt    = 0;

    function automatic logic [3:0] nib_of(input logic [15:0] w, input int i);
        logic [15:0] s;
        s = w >> (4 * (3 - i));
        return s[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mdl_accept(input logic [15:0] w);
        exp_t e;
        m_active = 1;
        m_word   = w;
        m_cnt    = 0;
        e.is_done = 0; e.nib = nib_of(w, 0); e.idx = 2'd0;
        sb.push_back(e);
    endtask

    task automatic mdl_press();
        exp_t e;
        if (m_active) begin
            if (m_cnt < 3) begin
                m_cnt++;
                e.is_done = 0; e.nib = nib_of(m_word, m_cnt); e.idx = 2'(m_cnt);
            end else begin
                m_active = 0;
                e.is_done = 1; e.nib = 4'h0; e.idx = 2'd0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic mdl_reset();
        m_active = 0;
        m_cnt    = 0;
        sb.delete();
    endtask

    // Monitor: pop an expectation whenever a new nibble or a done pulse appears
    logic       prev_valid = 0;
    logic       prev_done  = 0;
    logic [1:0] prev_idx   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0; prev_done = 0; prev_idx = 0;
        end else begin
            if (nib_valid && (!prev_valid || nib_idx != prev_idx)) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_nibble: got idx %0d nib %0h, expected no event (t=%0t)", nib_idx, nib_out, $time);
                end else begin
                    e = sb.pop_front();
                    if (e.is_done) begin
                        n_cmp++; n_bad++;
                        $display("FAIL event_order: got nibble idx %0d, expected done pulse (t=%0t)", nib_idx, $time);
                    end else begin
                        check("mon_nib_out", nib_out, e.nib);
                        check("mon_nib_idx", nib_idx, e.idx);
                    end
                end
            end
            if (!nib_valid) begin
                check("invalid_nib_out_zero", nib_out, 0);
                check("invalid_nib_idx_zero", nib_idx, 0);
            end
            if (done) begin
                check("done_pulse_width", prev_done, 0);
                if (!prev_done) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got done=1, expected no event (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        n_cmp++;
                        if (!e.is_done) begin
                            n_bad++;
                            $display("FAIL event_order: got done pulse, expected nibble idx %0d (t=%0t)", e.idx, $time);
                        end
                    end
                end
            end
            prev_valid = nib_valid;
            prev_done  = done;
            prev_idx   = nib_idx;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input logic [15:0] w);
        int guard;
        guard = 0;
        while (!word_ready && guard < 50) begin
            tick(1);
            guard++;
        end
        check("ready_before_accept", word_ready, 1);
        mdl_accept(w);
        word_in    = w;
        word_valid = 1;
        tick(1);
        word_valid = 0;
        word_in    = 16'($urandom);
    endtask

    // Generic press: pulse the button long enough to pass any synchronizer, then release
    task automatic press();
        mdl_press();
        btn = 1;
        tick(LAT + 1);
        btn = 0;
        tick(2);
        if (m_active) begin
            check("nib_after_press", nib_out, nib_of(m_word, m_cnt));
            check("idx_after_press", nib_idx, m_cnt);
        end else begin
            check("ready_after_press", word_ready, 1);
        end
    endtask

    // Press with edge-exact latency checks; button rises just after a clock edge
    task automatic press_timed();
        logic [1:0] old_idx;
        bit         last;
        old_idx = nib_idx;
        last    = (m_cnt == 3);
        mdl_press();
        btn = 1;
        for (int i = 0; i < LAT; i++) @(posedge clk);
        @(negedge clk);
        check("pre_advance_idx", nib_idx, old_idx);
        check("pre_advance_valid", nib_valid, 1);
        @(negedge clk);
        if (last) begin
            check("last_valid_fall", nib_valid, 0);
            check("last_done_high", done, 1);
            check("last_ready_low", word_ready, 0);
            @(negedge clk);
            check("done_cleared", done, 0);
            check("ready_after_done", word_ready, 1);
        end else begin
            check("timed_idx", nib_idx, m_cnt);
            check("timed_nib", nib_out, nib_of(m_word, m_cnt));
        end
        @(posedge clk);
        #1;
        btn = 0;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; btn = 0; word_valid = 0; word_in = 16'h0;
        #3;
        check("rst_word_ready", word_ready, 1);
        check("rst_nib_valid", nib_valid, 0);
        check("rst_nib_out", nib_out, 0);
        check("rst_nib_idx", nib_idx, 0);
        check("rst_done", done, 0);
        tick(2);
        rst = 0;
        tick(1);

        // Basic replay with exact press latency
        accept(16'hBF18);
        check("first_nib", nib_out, 4'hB);
        check("first_idx", nib_idx, 0);
        for (int i = 0; i < 4; i++) press_timed();
        tick(1);

        // Producer ignored in SHOW, then a long hold advances only once
        accept(16'hBF18);
        for (int i = 0; i < 3; i++) begin
            word_in = 16'h0000; word_valid = 1;
            check("ready_low_in_show", word_ready, 0);
            tick(1);
        end
        word_valid = 0;
        check("show_ignored_word", nib_out, 4'hB);
        mdl_press();
        btn = 1;
        tick(20);
        check("hold_idx", nib_idx, 1);
        check("hold_nib", nib_out, 4'hF);
        btn = 0;
        tick(LAT + 2);
        check("hold_release_idx", nib_idx, 1);
        for (int i = 0; i < 3; i++) press();

        // Press in IDLE is discarded
        press();
        accept(16'h1234);
        check("idle_press_nib", nib_out, 4'h1);
        check("idle_press_idx", nib_idx, 0);
        for (int i = 0; i < 4; i++) press();

        // Press event coincident with accept is discarded
        btn = 1;
        tick(LAT);
        accept(16'h1234);
        tick(2);
        btn = 0;
        tick(LAT + 2);
        check("coincident_nib", nib_out, 4'h1);
        check("coincident_idx", nib_idx, 0);
        for (int i = 0; i < 4; i++) press();

        // Reset mid-word with button held across reset release
        accept(16'hBF18);
        press();
        press();
        check("pre_reset_nib", nib_out, 4'h1);
        check("pre_reset_idx", nib_idx, 2);
        rst = 1;
        btn = 1;
        mdl_reset();
        #1;
        check("async_rst_nib_out", nib_out, 0);
        check("async_rst_valid", nib_valid, 0);
        check("async_rst_done", done, 0);
        check("async_rst_ready", word_ready, 1);
        tick(2);
        rst = 0;
        tick(1);
        accept(16'h5A3C);
        tick(6);
        check("held_through_reset_idx", nib_idx, 0);
        check("held_through_reset_nib", nib_out, 4'h5);
        btn = 0;
        tick(LAT + 2);
        for (int i = 0; i < 4; i++) press();

        // Randomized words with idle presses and producer noise in SHOW
        for (int w = 0; w < 12; w++) begin
            if ($urandom_range(0, 2) == 0) press();
            accept(16'($urandom));
            while (m_active) begin
                tick($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    word_in = 16'($urandom); word_valid = 1;
                    check("ready_low_random", word_ready, 0);
                    tick(1);
                    word_valid = 0;
                end
                press();
            end
        end

        tick(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_unload16b.md
# nibble_unload16b

Reads a 16-bit word back out as four 4-bit nibbles, advancing one nibble per press of a slide/push button. It is the read-side counterpart of the 16-bit nibble-load register, which shifts nibbles in MSB-first. This block therefore presents them MSB-first, so a word loaded as 1011,1111,0001,1000 replays in the same order. It sits between the word producer (register or datapath) and the 4-bit LED/seven-segment output.

## Interface
- No parameters; width fixed at 16 bits / 4 nibbles.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- word_in  input  16  word to unload; sampled only on accept
- word_valid  input  1  producer offers word_in
- word_ready  output  1  block idle and able to accept a word
- unloadButton_s  input  1  advance button, active-high level
- nib_out  output  4  currently presented nibble
- nib_valid  output  1  nib_out holds a nibble of the current word
- nib_idx  output  2  index of presented nibble (0 = bits 15:12 … 3 = bits 3:0)
- done  output  1  one-cycle pulse after the last nibble is advanced past

## Operation
- States: IDLE, SHOW, DONE. word_ready = (state == IDLE).
- IDLE: nib_valid=0, nib_out=0, nib_idx=0. Accept when word_valid && word_ready. On accept, shreg <= word_in, cnt <= 0, go to SHOW.
- SHOW: nib_out = shreg[15:12], nib_valid=1, nib_idx=cnt.
- SHOW press event, cnt < 3: shreg <= shreg << 4 (zero fill), cnt <= cnt+1.
- SHOW press event, cnt == 3: go to DONE, nib_valid <= 0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Press event = rising edge of the (optionally synchronized) button. Holding the button never repeats; it must be released and pressed again.
- Press in IDLE or DONE: discarded, no effect, no queuing.
- word_valid outside IDLE: ignored; the word is not captured.
- Press event in the same cycle as an accept: accept wins and the press is discarded. The first nibble is always shown for at least one press.
- Reset (any state, including mid-word):
  - state=IDLE, shreg=0, cnt=0.
  - nib_out=0, nib_valid=0, nib_idx=0, done=0, word_ready=1.
  - Button history registers reset to 1, so a button held through reset release does not fire.

## Timing
- Accept at edge N: nib_out/nib_valid/nib_idx reflect nibble 0 after edge N.
- Without sync: button high before edge K, low before edge K-1. nib_out advances after edge K.
- With sync: advance occurs after edge K+2 (two synchronizer stages).
- Last press at edge K: nib_valid falls and DONE entered after K; done high during cycle K..K+1; word_ready high after K+1.
- Minimum word turnaround: 1 accept cycle + 4 press events + 1 DONE cycle.
- Outputs are registered or decoded from state only; there is no combinational path from word_valid or the button to any output.

## Configuration
- UNLOAD_BTN_SYNC_EN defined: unloadButton_s passes through a 2-flop synchronizer (both flops reset to 1) before edge detect. Adds 2 cycles of press latency; safe for raw board buttons.
- Undefined: unloadButton_s is treated as already synchronous to clk (debounced upstream). Edge detect uses a single history flop; press latency is 0 extra cycles.

## Test plan
- Reset, then word_in=16'hBF18 with word_valid pulse, then 4 presses. Required: nib_out sequence B,F,1,8 with nib_idx 0..3, then nib_valid=0, a single done pulse, and word_ready=1.
- Hold button high for 20 cycles in SHOW. Required: exactly one advance (B→F); no further change until release and re-press.
- Offer word_valid with 16'h0000 while in SHOW on 16'hBF18. Required: ignored, word_ready=0, remaining nibbles still F,1,8.
- Press in IDLE, then accept 16'h1234. Required: nib_out=1, nib_idx=0; the earlier press is not applied. Press coincident with accept also leaves nib_out=1.
- Assert rst after two presses (nib_out=1, nib_idx=2). Required: immediately nib_out=0, nib_valid=0, done=0, word_ready=1. Button held across reset release gives no advance on the next word.
- With UNLOAD_BTN_SYNC_EN defined, repeat the first scenario. Required: each advance occurs 2 edges later than without the macro; nibble order unchanged.
